// File: rtl/kmeans_pkg.sv
// Shared constants and FSM state type for the k-means convergence sequencer.
package kmeans_pkg;

  localparam int DATA_WIDTH = 91;
  localparam int CENT_NUM   = 8;
  localparam int IDX_WIDTH  = 3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    STREAM   = 2'd1,
    WAIT_RES = 2'd2,
    REPORT   = 2'd3
  } state_t;

endpackage

// File: rtl/convergence_sequencer_if.sv
// Centroid handshake from the new-means block plus the convergence-checker port.
interface convergence_sequencer_if #(
  parameter int DATA_WIDTH = kmeans_pkg::DATA_WIDTH
);

  logic                           cent_valid;
  logic [DATA_WIDTH-1:0]          cent_data;
  logic                           cent_ready;
  logic [DATA_WIDTH-1:0]          chk_centroid;
  logic [kmeans_pkg::IDX_WIDTH-1:0] chk_cent_num;
  logic                           chk_reg_en;
  logic                           chk_regs_reset;
  logic                           chk_has_converged;
  logic                           chk_res_available;

  modport master (
    input  cent_valid, cent_data, chk_has_converged, chk_res_available,
    output cent_ready, chk_centroid, chk_cent_num, chk_reg_en, chk_regs_reset
  );

  modport slave (
    output cent_valid, cent_data, chk_has_converged, chk_res_available,
    input  cent_ready, chk_centroid, chk_cent_num, chk_reg_en, chk_regs_reset
  );

endinterface

// File: rtl/convergence_sequencer.sv
// Streams one iteration's centroids into the convergence checker and tracks
// iteration count, convergence and the iteration limit.
//
// state    | meaning
// IDLE     | waiting for start; checker held cleared
// STREAM   | accepting centroids, forwarding each to the checker
// WAIT_RES | all centroids sent, waiting for checker result
// REPORT   | one-cycle iter_done pulse, checker cleared
module convergence_sequencer
  import kmeans_pkg::*;
#(
  parameter int DATA_WIDTH = kmeans_pkg::DATA_WIDTH,
  parameter int CENT_NUM   = kmeans_pkg::CENT_NUM,
  parameter int ITER_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  restart,
  input  logic [ITER_WIDTH-1:0] max_iter,
  convergence_sequencer_if.master bus,
  output logic                  iter_done,
  output logic                  converged,
  output logic                  max_iter_reached,
  output logic [ITER_WIDTH-1:0] iter_count,
  output logic                  busy
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(CENT_NUM - 1);

  state_t                state, state_nxt;
  logic [IDX_WIDTH-1:0]  idx, idx_nxt;
  logic [ITER_WIDTH-1:0] count_nxt;
  logic                  conv_nxt, maxr_nxt;

  logic                  cent_ready, reg_en, regs_reset;
  logic [IDX_WIDTH-1:0]  cent_num;
  logic [DATA_WIDTH-1:0] centroid;

  always_ff @(posedge clk) begin
    if (!rst_n || restart) begin
      state            <= IDLE;
      idx              <= '0;
      iter_count       <= '0;
      converged        <= 1'b0;
      max_iter_reached <= 1'b0;
    end else begin
      state            <= state_nxt;
      idx              <= idx_nxt;
      iter_count       <= count_nxt;
      converged        <= conv_nxt;
      max_iter_reached <= maxr_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    count_nxt  = iter_count;
    conv_nxt   = converged;
    maxr_nxt   = max_iter_reached;
    cent_ready = 1'b0;
    reg_en     = 1'b0;
    cent_num   = '0;
    regs_reset = 1'b0;
    iter_done  = 1'b0;

    case (state)
      IDLE: begin
        if (start && !converged && !max_iter_reached) state_nxt = STREAM;
      end
      STREAM: begin
        cent_ready = 1'b1;
        regs_reset = 1'b1;
        if (bus.cent_valid) begin
          reg_en   = 1'b1;
          cent_num = idx;
          if (idx == LAST_IDX) begin
            idx_nxt   = '0;
            state_nxt = WAIT_RES;
          end else begin
            idx_nxt = idx + IDX_WIDTH'(1);
          end
        end
      end
      WAIT_RES: begin
        regs_reset = 1'b1;
        if (bus.chk_res_available) begin
          conv_nxt  = bus.chk_has_converged;
          count_nxt = (iter_count == '1) ? iter_count : iter_count + ITER_WIDTH'(1);
          // A zero limit means "stop after the first iteration".
          if (max_iter == '0 || count_nxt == max_iter) maxr_nxt = 1'b1;
          state_nxt = REPORT;
        end
      end
      REPORT: begin
        iter_done = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign centroid           = bus.cent_data;
  assign bus.chk_centroid   = centroid;
  assign bus.cent_ready     = cent_ready;
  assign bus.chk_reg_en     = reg_en;
  assign bus.chk_cent_num   = cent_num;
  assign bus.chk_regs_reset = regs_reset;
  assign busy               = (state != IDLE);

endmodule

// File: doc/convergence_sequencer.md
CONVERGENCE_SEQUENCER -- requirements
Module: convergence_sequencer

Interface
REQ-001 Parameter DATA_WIDTH, default 91, packed centroid width (7 coords x 13 bits).
REQ-002 Parameter CENT_NUM, default 8, centroids per iteration; index width 3.
REQ-003 Parameter ITER_WIDTH, default 8, iteration counter width.
REQ-004 clk  in  1  clock, all state on rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 start  in  1  pulse, begin one convergence check.
REQ-007 restart  in  1  pulse, clear iteration count and sticky flags.
REQ-008 max_iter  in  ITER_WIDTH  iteration limit, static during a run.
REQ-009 cent_valid  in  1  new-means block offers a centroid.
REQ-010 cent_data  in  DATA_WIDTH  offered centroid.
REQ-011 cent_ready  out  1  sequencer accepts a centroid this cycle.
REQ-012 chk_centroid  out  DATA_WIDTH  centroid to checker (new_centroid_in).
REQ-013 chk_cent_num  out  3  centroid index to checker.
REQ-014 chk_reg_en  out  1  checker count enable.
REQ-015 chk_regs_reset  out  1  checker clear, active-low (0 clears, 1 keeps).
REQ-016 chk_has_converged  in  1  checker result.
REQ-017 chk_res_available  in  1  checker result strobe.
REQ-018 iter_done  out  1  one-cycle pulse, iteration result ready.
REQ-019 converged  out  1  sticky, last check passed.
REQ-020 max_iter_reached  out  1  sticky, iter_count reached max_iter.
REQ-021 iter_count  out  ITER_WIDTH  completed iterations.
REQ-022 busy  out  1  state != IDLE.

Function
REQ-023 FSM states IDLE, STREAM, WAIT_RES, REPORT; IDLE->STREAM on start when neither converged nor max_iter_reached, else start ignored.
REQ-024 STREAM: cent_ready=1; transfer = cent_valid; on transfer chk_reg_en=1, chk_centroid=cent_data combinationally, chk_cent_num=index, index increments.
REQ-025 No transfer: chk_reg_en=0, chk_cent_num=0, index holds; chk_centroid=cent_data regardless.
REQ-026 Transfer with index 7: index wraps to 0, next state WAIT_RES.
REQ-027 chk_regs_reset=1 in STREAM and WAIT_RES, 0 in IDLE and REPORT.
REQ-028 WAIT_RES: when chk_res_available=1 latch converged<=chk_has_converged, iter_count increments (saturating at max), next REPORT; otherwise stay.
REQ-029 max_iter_reached set on the WAIT_RES->REPORT edge when incremented iter_count==max_iter; max_iter=0 sets it on first iteration.
REQ-030 REPORT: iter_done=1 for exactly one cycle, then IDLE.
REQ-031 Latency: start at cycle N, 8 back-to-back transfers N+1..N+8, chk_res_available N+9, iter_done N+10.
REQ-032 restart any state: next state IDLE, index=0, iter_count=0, converged=0, max_iter_reached=0; start in same cycle ignored.
REQ-033 start while busy ignored.

Reset
REQ-034 rst_n=0: state IDLE, index 0, iter_count 0, converged 0, max_iter_reached 0, iter_done 0, cent_ready 0, chk_reg_en 0, chk_cent_num 0, chk_regs_reset 0, busy 0.

Structure
REQ-035 kmeans_pkg holds DATA_WIDTH, CENT_NUM, index width and the FSM state enum.
REQ-036 Single module, no sub-module.

Verification
REQ-037 start, 8 back-to-back valids, checker returns converged=1 -> iter_done at start+10, converged=1, iter_count=1.
REQ-038 valid gaps after centroid 3 and 7 -> chk_cent_num=0 and chk_reg_en=0 in gap cycles, indices 0..7 each sent once.
REQ-039 max_iter=2, checker returns 0 twice -> max_iter_reached=1 after second iter_done, third start ignored.
REQ-040 restart during STREAM at index 4 -> IDLE next cycle, chk_regs_reset=0, iter_count=0, next start sends index 0.
REQ-041 rst_n low in WAIT_RES -> all outputs at reset values next cycle, no iter_done.
